// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 matrix keypad scanner.
//   db_state_t         : debounce FSM states
//   KEY_MAP            : hex code per key, indexed {row[1:0], col[1:0]}
//   RESULT_NONE        : frame result meaning "no single key seen"
//   count_lows_sat     : number of active rows in a column, saturated at 2
// A frame result is 5 bits: {none_flag, hex_code}. A key result has the flag
// clear, so comparing a result against {1'b0, code} also rejects NONE.
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } db_state_t;

  // Entry 15 is leftmost: row 3 / col 3 down to row 0 / col 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,   // row 3, cols 3..0
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  localparam int          RESULT_W    = 5;
  localparam logic [4:0]  RESULT_NONE = 5'b1_0000;

  // Only 0, 1 or "more than one" matters for frame evaluation.
  function automatic logic [1:0] count_lows_sat(input logic [3:0] lows);
    logic [2:0] n;
    n = 3'(lows[0]) + 3'(lows[1]) + 3'(lows[2]) + 3'(lows[3]);
    return (n > 3'd2) ? 2'd2 : n[1:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a bus of independent asynchronous level signals.
//   clk      in   destination clock
//   rst      in   synchronous reset, active high (loads RST_VAL)
//   i_async  in   WIDTH asynchronous inputs
//   o_sync   out  WIDTH synchronised outputs, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, forms a per-frame
// result (one key, or NONE for zero / multiple keys) and debounces it over
// DEBOUNCE_FRAMES consecutive frames.
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   row_in     in   [3:0] rows, active low, asynchronous
//   col_out    out  [3:0] column drive, active low, one bit low at a time
//   key_code   out  [3:0] hex code of accepted key, held after release
//   key_valid  out  high while an accepted key is held
//   key_pulse  out  one-cycle strobe on each newly accepted press
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_TICKS      = 100000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pulse
);

  import keypad_pkg::*;

  localparam int                TICK_W    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int                CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_FRAMES);

  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  // Row synchronisation: idle rows read high
  logic [3:0] w_rows_sync;

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (row_in),
    .o_sync  (w_rows_sync)
  );

  // Scan timing and per-frame accumulation
  logic [TICK_W-1:0]   r_tick;
  logic [1:0]          r_col_idx;
  logic [1:0]          r_acc_cnt;
  logic [3:0]          r_acc_idx;

  logic                w_sample;
  logic                w_frame_edge;
  logic [3:0]          w_lows;
  logic [1:0]          w_col_cnt;
  logic [1:0]          w_row_sel;
  logic [1:0]          w_tot_cnt;
  logic [3:0]          w_tot_idx;
  logic [RESULT_W-1:0] w_result;

  assign w_sample     = (r_tick == TICK_LAST);
  assign w_frame_edge = w_sample && (r_col_idx == 2'd3);
  assign w_lows       = ~w_rows_sync;
  assign w_col_cnt    = count_lows_sat(w_lows);
  assign w_tot_cnt    = sat_add2(r_acc_cnt, w_col_cnt);

  // Lowest active row; only meaningful when exactly one row is low
  always_comb begin
    w_row_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_lows[i]) w_row_sel = 2'(i);
    end
  end

  // The index only matters when the frame total ends at exactly one press
  assign w_tot_idx = (w_col_cnt != 2'd0) ? {w_row_sel, r_col_idx} : r_acc_idx;
  assign w_result  = (w_tot_cnt == 2'd1) ? {1'b0, KEY_MAP[w_tot_idx]} : RESULT_NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick    <= '0;
      r_col_idx <= 2'd0;
      col_out   <= 4'b1110;
      r_acc_cnt <= 2'd0;
    end else if (w_sample) begin
      r_tick    <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      col_out   <= ~(4'b0001 << (r_col_idx + 2'd1));
      r_acc_cnt <= w_frame_edge ? 2'd0 : w_tot_cnt;
    end else begin
      r_tick    <= r_tick + TICK_W'(1);
    end
  end

  // Accumulated key index is data: the count alone marks it as empty
  always_ff @(posedge clk) begin
    if (w_sample) r_acc_idx <= w_tot_idx;
  end

  // Debounce FSM, stepped only on frame-evaluation edges
  db_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]       r_cand, w_cand_nxt;
  logic [3:0]       w_code_nxt;
  logic             w_valid_nxt;
  logic             w_pulse_nxt;
  logic             w_is_cand;
  logic             w_is_held;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_is_cand = (w_result == {1'b0, r_cand});
  assign w_is_held = (w_result == {1'b0, key_code});

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_code_nxt  = key_code;
    w_valid_nxt = key_valid;
    w_pulse_nxt = 1'b0;
    if (w_frame_edge) begin
      case (r_state)
        RELEASED: begin
          if (!w_result[4]) begin
            w_state_nxt = PRESS_DB;
            w_cand_nxt  = w_result[3:0];
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        PRESS_DB: begin
          if (w_result[4]) begin
            w_state_nxt = RELEASED;
          end else if (w_is_cand) begin
            if (w_cnt_inc == CNT_DONE) begin
              w_state_nxt = PRESSED;
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
              w_pulse_nxt = 1'b1;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            // A different single key restarts the count on the new candidate
            w_cand_nxt  = w_result[3:0];
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!w_is_held) begin
            w_state_nxt = REL_DB;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        REL_DB: begin
          if (w_is_held) begin
            w_state_nxt = PRESSED;
          end else if (w_cnt_inc == CNT_DONE) begin
            w_state_nxt = RELEASED;
            w_valid_nxt = 1'b0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: w_state_nxt = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      key_code  <= w_code_nxt;
      key_valid <= w_valid_nxt;
      key_pulse <= w_pulse_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_cand <= w_cand_nxt;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Bench for keypad_scanner with SCAN_TICKS=8, DEBOUNCE_FRAMES=3 (32-cycle
// frames). A keypad model pulls a row low whenever a pressed key's column is
// driven low. Positions below count rising edges since reset was released and
// are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int ST = 8;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pulse;
  logic [15:0] keys = '0;   // pressed keys, bit index {row,col}

  int n_checks   = 0;
  int n_pass     = 0;
  int pulse_seen = 0;

  typedef struct {
    int         pos;
    logic [3:0] col;
  } col_vec_t;

  typedef struct {
    string      name;
    int         idx;
    logic [3:0] code;
  } key_vec_t;

  col_vec_t cv[9];
  key_vec_t kv[11];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_TICKS      (ST),
    .DEBOUNCE_FRAMES (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance n rising edges, sampling on each falling edge and counting pulses
  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      if (key_pulse) pulse_seen++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_seen = 0;
  endtask

  initial begin
    int cur;

    cv = '{'{0, 4'b1110}, '{7, 4'b1110}, '{8, 4'b1101}, '{15, 4'b1101},
           '{16, 4'b1011}, '{24, 4'b0111}, '{31, 4'b0111}, '{32, 4'b1110},
           '{40, 4'b1101}};

    kv = '{'{"key5", 5, 4'h5}, '{"key1", 0, 4'h1}, '{"keyA", 3, 4'hA},
           '{"key0", 12, 4'h0}, '{"keyD", 15, 4'hD}, '{"key9", 10, 4'h9},
           '{"key7", 8, 4'h7}, '{"keyF", 13, 4'hF}, '{"keyE", 14, 4'hE},
           '{"keyB", 7, 4'hB}, '{"keyC", 11, 4'hC}};

    // Idle scan after reset
    keys = '0;
    do_reset();
    check("rst_code", 32'(key_code), 0);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_pulse", 32'(key_pulse), 0);
    cur = 0;
    for (int i = 0; i < 9; i++) begin
      adv(cv[i].pos - cur);
      cur = cv[i].pos;
      check($sformatf("col_at_%0d", cv[i].pos), 32'(col_out), 32'(cv[i].col));
    end
    adv(320 - cur);
    check("idle_pulses", pulse_seen, 0);
    check("idle_valid", 32'(key_valid), 0);

    // Each key held from reset: accepted on the third frame edge (P96)
    for (int i = 0; i < 11; i++) begin
      keys = 16'(1) << kv[i].idx;
      do_reset();
      adv(95);
      check({kv[i].name, "_early_valid"}, 32'(key_valid), 0);
      adv(1);
      check({kv[i].name, "_valid"}, 32'(key_valid), 1);
      check({kv[i].name, "_pulse"}, 32'(key_pulse), 1);
      check({kv[i].name, "_code"}, 32'(key_code), 32'(kv[i].code));
      adv(1);
      check({kv[i].name, "_pulse_end"}, 32'(key_pulse), 0);
      check({kv[i].name, "_pulse_cnt"}, pulse_seen, 1);
    end

    // Hold '5' for ten more frames: no repeat pulse
    keys = 16'(1) << 5;
    do_reset();
    adv(97 + 320);
    check("hold5_pulses", pulse_seen, 1);
    check("hold5_valid", 32'(key_valid), 1);
    check("hold5_code", 32'(key_code), 5);

    // 'D' for 4 frames then released: valid falls at the third NONE edge
    keys = 16'(1) << 15;
    do_reset();
    adv(128);
    check("D_code", 32'(key_code), 32'hD);
    keys = '0;
    adv(95);
    check("D_rel_valid_223", 32'(key_valid), 1);
    adv(1);
    check("D_rel_valid_224", 32'(key_valid), 0);
    check("D_rel_code", 32'(key_code), 32'hD);
    adv(32);
    check("D_rel_code_hold", 32'(key_code), 32'hD);
    check("D_rel_pulses", pulse_seen, 1);

    // '7' bouncing frame by frame, then a one-frame glitch while pressed
    keys = '0;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      keys = (f % 2 == 0) ? (16'(1) << 8) : 16'h0000;
      adv(32);
    end
    check("bounce7_pulses", pulse_seen, 0);
    check("bounce7_valid", 32'(key_valid), 0);
    keys = 16'(1) << 8;
    adv(96);
    check("hold7_pulses", pulse_seen, 1);
    check("hold7_valid", 32'(key_valid), 1);
    keys = '0;
    adv(32);
    check("glitch7_valid", 32'(key_valid), 1);
    keys = 16'(1) << 8;
    adv(64);
    check("glitch7_valid_after", 32'(key_valid), 1);
    check("glitch7_pulses", pulse_seen, 1);
    check("glitch7_code", 32'(key_code), 7);

    // '1' + 'D' together reads NONE; releasing 'D' lets '1' through
    keys = (16'(1) << 0) | (16'(1) << 15);
    do_reset();
    adv(192);
    check("multi_pulses", pulse_seen, 0);
    check("multi_valid", 32'(key_valid), 0);
    keys = 16'(1) << 0;
    adv(95);
    check("single1_early_valid", 32'(key_valid), 0);
    adv(1);
    check("single1_pulse", 32'(key_pulse), 1);
    check("single1_code", 32'(key_code), 1);

    // Reset in PRESS_DB after two frames of '9', in column 2
    keys = 16'(1) << 10;
    do_reset();
    adv(80);
    check("pre_rst_col", 32'(col_out), 32'b1011);
    check("pre_rst_valid", 32'(key_valid), 0);
    rst = 1'b1;
    adv(1);
    check("mid_rst_col", 32'(col_out), 32'b1110);
    check("mid_rst_valid", 32'(key_valid), 0);
    check("mid_rst_pulse", 32'(key_pulse), 0);
    check("mid_rst_code", 32'(key_code), 0);
    rst = 1'b0;
    pulse_seen = 0;
    adv(33);
    check("post_rst_valid_33", 32'(key_valid), 0);
    adv(62);
    check("post_rst_valid_95", 32'(key_valid), 0);
    check("post_rst_pulses_95", pulse_seen, 0);
    adv(1);
    check("post_rst_pulse", 32'(key_pulse), 1);
    check("post_rst_code", 32'(key_code), 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
